multi_lane_load_serializer: RTL
===============================

Name: multi_lane_load_serializer

Overview:
Parametrised successor to the single-lane 16-bit load serializer that drives the chip's shift-register configuration chains. It shifts N_CH words of DATA_W bits out in parallel, one SRI lane per channel, on a shared serial clock (SCLK) and a shared active-low load strobe (LD_n). SCLK low/high timing and bit order are set at run time. A start/busy/done handshake, a synchronous abort, and a back-to-back transfer capability are provided. The block sits between the register-bank/host-command logic and the sensor pads.

Parameters:
DATA_W, 16, bits per channel word (>=2)
N_CH, 2, number of parallel SRI lanes (>=1)
CNT_W, 10, width of timing inputs and internal phase counter

Ports:
CLK100MHZ  input  1  system clock, 100 MHz, all logic on rising edge
ser_cnt_reset  input  1  reset, asynchronous, active-high
start  input  1  transfer request, sampled only in IDLE
abort  input  1  synchronous abort, returns block to IDLE
data  input  N_CH*DATA_W  lane c word = data[(c+1)*DATA_W-1 : c*DATA_W], captured on accepted start
lsb_first  input  1  0 = MSB first, 1 = LSB first; captured on accepted start
t_lo  input  CNT_W  SCLK low-phase length in cycles; captured on accepted start
t_hi  input  CNT_W  SCLK high-phase length in cycles; captured on accepted start
SRI  output  N_CH  serial data lanes
SCLK  output  1  shared serial clock to the chains
LD_n  output  1  active-low load window, low for the whole transfer
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on normal completion

Behaviour:
- All outputs are registered. Reset values: SRI=0, SCLK=0, LD_n=1, busy=0, done=0, state=IDLE, counters=0.
- Effective timing: t_lo_e = max(t_lo,1); t_hi_e = max(t_hi,1). Both are latched at start, so later input changes do not affect an active transfer.
- States:
  - IDLE: accept start at edge E0 when start=1. Latch data into N_CH shift registers; latch mode and timing.
  - LOW: entered at E1. LD_n=0, busy=1, SCLK=0, SRI[c]=current bit of lane c (bit DATA_W-1 first for MSB mode, bit 0 first for LSB mode). Stay t_lo_e cycles, then go to HIGH.
  - HIGH: SCLK=1, SRI held. Stay t_hi_e cycles. When the phase ends, shift every lane by one and increment the bit counter.
    - If bits sent < DATA_W: go to LOW. SRI updates on the same edge SCLK falls.
    - Otherwise: go to TAIL.
  - TAIL: SCLK=0, SRI=0, LD_n=0 for t_lo_e cycles, then go to LATCH.
  - LATCH: LD_n=1, busy=0, done=1 for exactly one cycle, all asserted on the same edge. Return to IDLE.
- Cycle accounting:
  - Exactly DATA_W SCLK rising edges per transfer.
  - LD_n low for DATA_W*(t_lo_e+t_hi_e)+t_lo_e cycles.
  - First SCLK rise at E1+t_lo_e.
- Data is stable for at least t_lo_e cycles before each SCLK rise and held through the high phase.
- Start while busy=1 is ignored; no queueing.
- Back-to-back: start asserted during the LATCH/done cycle is accepted on the next edge, in IDLE. LD_n is therefore guaranteed high for at least 1 cycle between transfers.
- Abort (any non-IDLE state): on the next edge go to IDLE with LD_n=1, SCLK=0, SRI=0, busy=0, and no done pulse. Abort in IDLE has no effect. Abort and start together in IDLE: abort wins and start is ignored.
- Reset mid-transfer: outputs go immediately (asynchronously) to reset values. No done pulse. The partial load is not latched because LD_n is already high; the chain contents are undefined.
- All lanes share the counter and timing, so lanes are bit-synchronous.

Test Plan:
- DATA_W=16, N_CH=2, t_lo=3, t_hi=2, MSB mode, data={16'h0F0F,16'hA5C3}, pulse start. Required: SRI[0] at each SCLK rise = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; SRI[1] = 0000111100001111; 16 SCLK rises; LD_n low 83 cycles; done single-cycle on the LD_n rise edge.
- Same data with lsb_first=1. Required: SRI[0] sequence = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- t_lo=0, t_hi=0. Required: behaves as 1/1; SCLK period 2 cycles; LD_n low 33 cycles.
- Hold start high continuously. Required: consecutive transfers with LD_n high exactly 1 cycle between them. A start pulse mid-transfer, or a t_hi change mid-transfer, has no effect.
- Abort asserted after the 5th SCLK rise. Required: next edge LD_n=1, SCLK=0, SRI=0, busy=0; done never asserted; a new start afterwards completes normally.
- ser_cnt_reset asserted asynchronously mid-HIGH phase. Required: SCLK, SRI, busy, done go to 0 and LD_n goes to 1 without waiting for a clock edge; after release, IDLE and a fresh transfer matches the first scenario.

Source files
------------

// File: rtl/multi_lane_load_serializer.sv
// Multi-lane load serializer: shifts N_CH words out in parallel on a shared SCLK,
// framed by an active-low LD_n window, with start/busy/done handshake and abort.
module multi_lane_load_serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                     CLK100MHZ,
  input  logic                     ser_cnt_reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_CH*DATA_W-1:0]   data,
  input  logic                     lsb_first,
  input  logic [CNT_W-1:0]         t_lo,
  input  logic [CNT_W-1:0]         t_hi,
  output logic [N_CH-1:0]          SRI,
  output logic                     SCLK,
  output logic                     LD_n,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  // The one-cycle LATCH/done step is folded into the return to IDLE, so a start
  // held through the done cycle is accepted on the very next edge.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TAIL
  } state_t;

  state_t                        state_q;
  logic [N_CH-1:0][DATA_W-1:0]   sh_q;
  logic [N_CH-1:0][DATA_W-1:0]   sh_d;
  logic                          lsb_q;
  logic [CNT_W-1:0]              tlo_q;
  logic [CNT_W-1:0]              thi_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [BIT_W-1:0]              bit_q;
  logic [N_CH-1:0]               sri_q;
  logic                          sclk_q;
  logic                          ldn_q;
  logic                          busy_q;
  logic                          done_q;

  logic [CNT_W-1:0]              tlo_e;
  logic [CNT_W-1:0]              thi_e;
  logic [N_CH-1:0]               first_bits;
  logic [N_CH-1:0]               next_bits;
  logic                          lo_end;
  logic                          hi_end;
  logic                          last_bit;

  always_comb begin
    tlo_e = (t_lo == '0) ? CNT_W'(1) : t_lo;
    thi_e = (t_hi == '0) ? CNT_W'(1) : t_hi;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sh_d[c]       = lsb_q ? (sh_q[c] >> 1) : (sh_q[c] << 1);
      next_bits[c]  = lsb_q ? sh_q[c][1] : sh_q[c][DATA_W-2];
      first_bits[c] = lsb_first ? data[c*DATA_W] : data[c*DATA_W + DATA_W - 1];
    end
  end

  assign lo_end   = (cnt_q == tlo_q - CNT_W'(1));
  assign hi_end   = (cnt_q == thi_q - CNT_W'(1));
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));

  always_ff @(posedge CLK100MHZ or posedge ser_cnt_reset) begin
    if (ser_cnt_reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      lsb_q   <= 1'b0;
      tlo_q   <= '0;
      thi_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sri_q   <= '0;
      sclk_q  <= 1'b0;
      ldn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        bit_q   <= '0;
        sri_q   <= '0;
        sclk_q  <= 1'b0;
        ldn_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_LOW;
              sh_q    <= data;
              lsb_q   <= lsb_first;
              tlo_q   <= tlo_e;
              thi_q   <= thi_e;
              cnt_q   <= '0;
              bit_q   <= '0;
              sri_q   <= first_bits;
              sclk_q  <= 1'b0;
              ldn_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          S_LOW: begin
            if (lo_end) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
              sclk_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_HIGH: begin
            if (hi_end) begin
              cnt_q  <= '0;
              sh_q   <= sh_d;
              bit_q  <= bit_q + BIT_W'(1);
              sclk_q <= 1'b0;
              if (last_bit) begin
                state_q <= S_TAIL;
                sri_q   <= '0;
              end else begin
                state_q <= S_LOW;
                sri_q   <= next_bits;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_TAIL: begin
            if (lo_end) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              bit_q   <= '0;
              ldn_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign SRI  = sri_q;
  assign SCLK = sclk_q;
  assign LD_n = ldn_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
